// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: boots the program start address from M[0]/M[1],
// then serves fetch requests with one- or two-word instructions.
module instr_mem_responder #(
    parameter int unsigned addressWidth = 32,
    parameter int unsigned MEM_DEPTH    = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] wr_addr,
    input  logic [15:0]               wr_data,
    output logic [addressWidth-1:0]   start_addr,
    output logic                      start_valid,
    input  logic                      req_valid,
    input  logic [addressWidth-1:0]   req_addr,
    output logic                      req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_instr,
    output logic [1:0]                rsp_len,
    output logic [addressWidth-1:0]   rsp_addr
);

    localparam int unsigned IW = $clog2(MEM_DEPTH);

    localparam logic [1:0] S_BOOT0  = 2'd0;
    localparam logic [1:0] S_BOOT1  = 2'd1;
    localparam logic [1:0] S_IDLE   = 2'd2;
    localparam logic [1:0] S_FETCH2 = 2'd3;

    logic [15:0] mem_q [MEM_DEPTH];

    logic [1:0]              state_q, state_d;
    logic [addressWidth-1:0] start_addr_q, start_addr_d;
    logic                    start_valid_q, start_valid_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [31:0]             rsp_instr_q, rsp_instr_d;
    logic [1:0]              rsp_len_q, rsp_len_d;
    logic [addressWidth-1:0] rsp_addr_q, rsp_addr_d;
    logic [15:0]             word0_q, word0_d;

    logic [IW-1:0] idx0;
    logic [IW-1:0] idx1;
    logic [15:0]   word0;
    logic [15:0]   word1;
    logic          accept;
    logic          unused_addr_bits;

    // Only the low index bits address the memory.
    assign idx0  = req_addr[IW-1:0];
    assign idx1  = rsp_addr_q[IW-1:0] + IW'(1);
    assign word0 = mem_q[idx0];
    assign word1 = mem_q[idx1];
    assign unused_addr_bits = ^req_addr[addressWidth-1:IW];

    assign req_ready = (state_q == S_IDLE) && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d       = state_q;
        start_addr_d  = start_addr_q;
        start_valid_d = start_valid_q;
        rsp_valid_d   = rsp_valid_q && !rsp_ready;
        rsp_instr_d   = rsp_instr_q;
        rsp_len_d     = rsp_len_q;
        rsp_addr_d    = rsp_addr_q;
        word0_d       = word0_q;
        case (state_q)
            S_BOOT0: begin
                start_addr_d = addressWidth'(mem_q[IW'(0)]);
                state_d      = S_BOOT1;
            end
            S_BOOT1: begin
                start_addr_d  = addressWidth'({mem_q[IW'(1)], start_addr_q[15:0]});
                start_valid_d = 1'b1;
                state_d       = S_IDLE;
            end
            S_IDLE: begin
                if (accept) begin
                    rsp_addr_d = req_addr;
                    if (word0[15]) begin
                        word0_d = word0;
                        state_d = S_FETCH2;
                    end else begin
                        rsp_instr_d = {word0, 16'h0000};
                        rsp_len_d   = 2'd1;
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                rsp_instr_d = {word0_q, word1};
                rsp_len_d   = 2'd2;
                rsp_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_BOOT0;
            start_addr_q  <= '0;
            start_valid_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_instr_q   <= '0;
            rsp_len_q     <= '0;
            rsp_addr_q    <= '0;
            word0_q       <= '0;
        end else begin
            state_q       <= state_d;
            start_addr_q  <= start_addr_d;
            start_valid_q <= start_valid_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_instr_q   <= rsp_instr_d;
            rsp_len_q     <= rsp_len_d;
            rsp_addr_q    <= rsp_addr_d;
            word0_q       <= word0_d;
        end
    end

    // Program-load port; contents survive reset but loads are blocked during it.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign start_addr  = start_addr_q;
    assign start_valid = start_valid_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_instr   = rsp_instr_q;
    assign rsp_len     = rsp_len_q;
    assign rsp_addr    = rsp_addr_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder: directed boot/reset/backpressure
// sequences plus a vector table whose responses are matched through a queue.
module tb_instr_mem_responder;

    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned IW    = $clog2(DEPTH);

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [AW-1:0] start_addr;
    logic          start_valid;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_instr;
    logic [1:0]    rsp_len;
    logic [AW-1:0] rsp_addr;

    instr_mem_responder #(.addressWidth(AW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start_addr(start_addr), .start_valid(start_valid),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr), .rsp_len(rsp_len), .rsp_addr(rsp_addr)
    );

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  len;
        logic [31:0] addr;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [1:0]  len;
        int          waits;
    } vec_t;

    rsp_t exp_q[$];
    int   compared;
    int   mismatched;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [IW-1:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Present a request, wait (bounded) for acceptance, optionally queue its response.
    task automatic send(input logic [31:0] a, input logic [31:0] ei, input logic [1:0] el,
                        input bit expect_rsp, output int waits);
        rsp_t r;
        req_valid = 1'b1; req_addr = a; waits = 0;
        #1;
        while (!req_ready && waits < 20) begin
            @(posedge clk);
            #2;
            waits++;
        end
        if (!req_ready) begin
            compared++; mismatched++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 for addr %h", a);
        end else if (expect_rsp) begin
            r.instr = ei; r.len = el; r.addr = a;
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a response completing at the coming edge must match the queue head.
    always @(negedge clk) begin
        rsp_t r;
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_rsp", 64'(rsp_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                r = exp_q.pop_front();
                chk("sb_instr", 64'(rsp_instr), 64'(r.instr));
                chk("sb_len",   64'(rsp_len),   64'(r.len));
                chk("sb_addr",  64'(rsp_addr),  64'(r.addr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   w;

        compared = 0; mismatched = 0;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;

        vecs[0] = '{32'h0000_0040, 32'h1234_0000, 2'd1, 0};
        vecs[1] = '{32'h0000_0041, 32'h5678_0000, 2'd1, 0};
        vecs[2] = '{32'h0000_0042, 32'h9ABC_DEF0, 2'd2, 0};
        vecs[3] = '{32'h0000_1040, 32'h1234_0000, 2'd1, 1};
        vecs[4] = '{32'h0000_03FF, 32'h8001_00FF, 2'd2, 0};
        vecs[5] = '{32'h0000_0043, 32'hDEF0_0001, 2'd2, 1};
        vecs[6] = '{32'h0000_0041, 32'h5678_0000, 2'd1, 1};

        repeat (3) tick();
        chk("rst_req_ready",   64'(req_ready),   64'd0);
        chk("rst_rsp_valid",   64'(rsp_valid),   64'd0);
        chk("rst_rsp_instr",   64'(rsp_instr),   64'd0);
        chk("rst_rsp_len",     64'(rsp_len),     64'd0);
        chk("rst_rsp_addr",    64'(rsp_addr),    64'd0);
        chk("rst_start_valid", 64'(start_valid), 64'd0);
        chk("rst_start_addr",  64'(start_addr),  64'd0);

        rst = 1'b0;
        repeat (3) tick();
        wr(IW'(0), 16'h0040);
        wr(IW'(1), 16'h0001);
        wr(IW'(10'h040), 16'h1234);
        wr(IW'(10'h041), 16'h5678);
        wr(IW'(10'h042), 16'h9ABC);
        wr(IW'(10'h043), 16'hDEF0);
        wr(IW'(10'h044), 16'h0001);
        wr(IW'(10'h3FF), 16'h8001);
        wr(IW'(10'h050), 16'h5555);
        wr(IW'(10'h051), 16'h0000);

        // Reboot; the write during reset must be dropped.
        rst = 1'b1;
        tick();
        wr(IW'(1), 16'hFFFF);
        rst = 1'b0;
        tick();
        chk("boot_e1_start_valid", 64'(start_valid), 64'd0);
        chk("boot_e1_req_ready",   64'(req_ready),   64'd0);
        tick();
        chk("boot_e2_start_valid", 64'(start_valid), 64'd1);
        chk("boot_start_addr",     64'(start_addr),  64'h0001_0040);
        chk("boot_req_ready",      64'(req_ready),   64'd1);

        // Short fetch latency.
        send(32'h40, 32'h1234_0000, 2'd1, 1'b1, w);
        chk("short_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("short_rsp_instr", 64'(rsp_instr), 64'h1234_0000);
        chk("short_rsp_len",   64'(rsp_len),   64'd1);
        chk("short_rsp_addr",  64'(rsp_addr),  64'h40);
        req_valid = 1'b0;
        tick();

        // Start address is frozen after boot.
        wr(IW'(0), 16'h00FF);
        chk("start_addr_frozen", 64'(start_addr), 64'h0001_0040);

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].addr, vecs[i].instr, vecs[i].len, 1'b1, w);
            chk($sformatf("vec%0d_waits", i), 64'(w), 64'(vecs[i].waits));
        end
        req_valid = 1'b0;
        repeat (3) tick();

        // Long fetch wrapping past the last word.
        send(32'h3FF, 32'h8001_00FF, 2'd2, 1'b1, w);
        req_valid = 1'b0;
        chk("long_fetch2_req_ready", 64'(req_ready), 64'd0);
        chk("long_fetch2_rsp_valid", 64'(rsp_valid), 64'd0);
        tick();
        chk("long_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("long_rsp_instr", 64'(rsp_instr), 64'h8001_00FF);
        chk("long_rsp_len",   64'(rsp_len),   64'd2);
        tick();

        // Backpressure holds the response and blocks new requests.
        rsp_ready = 1'b0;
        send(32'h41, 32'h5678_0000, 2'd1, 1'b1, w);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_instr", 64'(rsp_instr), 64'h5678_0000);
            chk("bp_rsp_addr",  64'(rsp_addr),  64'h41);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_req_ready", 64'(req_ready), 64'd1);
        tick();
        tick();

        // Write/read collision on the same word.
        wr_en = 1'b1; wr_addr = IW'(10'h050); wr_data = 16'hAAAA;
        send(32'h50, 32'h5555_0000, 2'd1, 1'b1, w);
        wr_en = 1'b0;
        send(32'h50, 32'hAAAA_0000, 2'd2, 1'b1, w);
        req_valid = 1'b0;
        repeat (3) tick();

        // Reset during FETCH2 drops the fetch and reboots with current M[0]/M[1].
        wr(IW'(1), 16'h0002);
        send(32'h42, 32'h0, 2'd0, 1'b0, w);
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("midrst_rsp_valid",   64'(rsp_valid),   64'd0);
        chk("midrst_start_valid", 64'(start_valid), 64'd0);
        rst = 1'b0;
        tick();
        chk("reboot_e1_start_valid", 64'(start_valid), 64'd0);
        tick();
        chk("reboot_start_valid", 64'(start_valid), 64'd1);
        chk("reboot_start_addr",  64'(start_addr),  64'h0002_00FF);
        repeat (4) tick();

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
